// File: rtl/mmio_arb_pkg.sv
// Shared widths and the registered bus command type for the MMIO bus arbiter.
package mmio_arb_pkg;
    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } mmio_cmd_t;
endpackage

// File: rtl/mmio_bus_arbiter_rr.sv
// NM-way round-robin selector with a bounded lock that keeps the grant on one master.
module rr_arbiter #(
    parameter int NM       = 2,
    parameter int MAX_LOCK = 4,
    parameter int IW       = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NM-1:0] req_i,
    input  logic [NM-1:0] lock_i,
    output logic [NM-1:0] gnt_o,
    output logic [IW-1:0] gidx_o
);
    localparam logic [3:0] MAX_L = 4'(MAX_LOCK);

    logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d;
    logic          locked_q, locked_d;
    logic [3:0]    cnt_q, cnt_d, run;
    logic          found;

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NM) s -= NM;
        return IW'(s);
    endfunction

    always_comb begin
        gnt_o    = '0;
        gidx_o   = '0;
        found    = 1'b0;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        locked_d = 1'b0;
        cnt_d    = '0;
        if (locked_q && req_i[owner_q]) begin
            found  = 1'b1;
            gidx_o = owner_q;
        end else begin
            for (int k = 0; k < NM; k++) begin
                if (!found && req_i[wrap(ptr_q, k)]) begin
                    found  = 1'b1;
                    gidx_o = wrap(ptr_q, k);
                end
            end
        end
        // run = consecutive grants to this master, including this one
        run = (locked_q && owner_q == gidx_o) ? cnt_q + 4'd1 : 4'd1;
        if (found) begin
            gnt_o[gidx_o] = 1'b1;
            ptr_d         = wrap(gidx_o, 1);
            if (lock_i[gidx_o] && run < MAX_L) begin
                locked_d = 1'b1;
                owner_d  = gidx_o;
                cnt_d    = run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares the FPro MMIO bus between NM masters: registered command issue and
// a two-stage read-return pipeline tagged with the originating master.
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int NM       = 2,
    parameter int MAX_LOCK = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NM-1:0]                m_req,
    input  logic [NM-1:0]                m_wr,
    input  logic [NM-1:0]                m_lock,
    input  logic [NM-1:0][ADDR_W-1:0]    m_addr,
    input  logic [NM-1:0][DATA_W-1:0]    m_wr_data,
    output logic [NM-1:0]                m_gnt,
    output logic [NM-1:0]                m_rd_valid,
    output logic [DATA_W-1:0]            m_rd_data,
    output logic                         mmio_cs,
    output logic                         mmio_wr,
    output logic                         mmio_rd,
    output logic [ADDR_W-1:0]            mmio_addr,
    output logic [DATA_W-1:0]            mmio_wr_data,
    input  logic [DATA_W-1:0]            mmio_rd_data
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    logic [NM-1:0]         arb_gnt;
    logic [IW-1:0]         gidx;
    mmio_cmd_t             cmd_q, cmd_d;
    logic                  cs_q;
    logic [1:0]            rd_vld_q;
    logic [1:0][IW-1:0]    tag_q;
    logic [DATA_W-1:0]     rd_data_q;

    rr_arbiter #(.NM(NM), .MAX_LOCK(MAX_LOCK), .IW(IW)) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req_i  (m_req),
        .lock_i (m_lock),
        .gnt_o  (arb_gnt),
        .gidx_o (gidx)
    );

    // Nothing is accepted while reset is held, so no command can be lost to it.
    assign m_gnt = reset ? '0 : arb_gnt;

    always_comb begin
        cmd_d = '0;
        if (|m_gnt) begin
            cmd_d.wr      = m_wr[gidx];
            cmd_d.addr    = m_addr[gidx];
            cmd_d.wr_data = m_wr_data[gidx];
        end
    end

    // rd_vld_q[0]: read on the bus now; rd_vld_q[1]: captured data being returned
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q      <= 1'b0;
            cmd_q     <= '0;
            rd_vld_q  <= '0;
            tag_q     <= '0;
            rd_data_q <= '0;
        end else begin
            cs_q     <= |m_gnt;
            cmd_q    <= cmd_d;
            rd_vld_q <= {rd_vld_q[0], (|m_gnt) & ~m_wr[gidx]};
            tag_q    <= {tag_q[0], gidx};
            if (rd_vld_q[0]) rd_data_q <= mmio_rd_data;
        end
    end

    assign mmio_cs      = cs_q;
    assign mmio_wr      = cs_q & cmd_q.wr;
    assign mmio_rd      = cs_q & ~cmd_q.wr;
    assign mmio_addr    = cmd_q.addr;
    assign mmio_wr_data = cmd_q.wr_data;
    assign m_rd_data    = rd_data_q;

    always_comb begin
        m_rd_valid = '0;
        if (rd_vld_q[1]) m_rd_valid[tag_q[1]] = 1'b1;
    end
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed scenarios plus randomized traffic checked against a behavioural bus model.
module tb_mmio_bus_arbiter;
    localparam int NM       = 2;
    localparam int MAX_LOCK = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NM-1:0]       m_req, m_wr, m_lock;
    logic [NM-1:0][20:0] m_addr;
    logic [NM-1:0][31:0] m_wr_data;
    logic [NM-1:0]       m_gnt, m_rd_valid;
    logic [31:0]         m_rd_data;
    logic                mmio_cs, mmio_wr, mmio_rd;
    logic [20:0]         mmio_addr;
    logic [31:0]         mmio_wr_data, mmio_rd_data;
    logic [31:0]         bus_data;
    bit                  use_hash;
    int                  nchk = 0;
    int                  nfail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] hashf(input logic [20:0] a);
        return {a[10:0], a} ^ 32'h9E3779B9;
    endfunction

    assign mmio_rd_data = use_hash ? hashf(mmio_addr) : bus_data;

    mmio_bus_arbiter #(.NM(NM), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_lock(m_lock),
        .m_addr(m_addr), .m_wr_data(m_wr_data), .m_gnt(m_gnt), .m_rd_valid(m_rd_valid),
        .m_rd_data(m_rd_data), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
    );

    task automatic tick; @(posedge clk); #1; endtask
    task automatic smp;  @(negedge clk); endtask
    task automatic idle_inputs;
        m_req = '0; m_wr = '0; m_lock = '0; m_addr = '0; m_wr_data = '0;
    endtask
    task automatic do_reset;
        tick; reset = 1'b1; idle_inputs; tick; tick; reset = 1'b0;
    endtask

    function automatic logic [91:0] all_outs();
        return {m_gnt, m_rd_valid, m_rd_data, mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data};
    endfunction

    task automatic test_reset;
        reset = 1'b1; idle_inputs; bus_data = '0; use_hash = 1'b0;
        tick; tick; smp;
        nchk++;
        if (all_outs() !== '0) begin nfail++; $display("FAIL reset_hold: got %h want 0", all_outs()); end
        tick; reset = 1'b0; smp;
        nchk++;
        if (all_outs() !== '0) begin nfail++; $display("FAIL reset_release: got %h want 0", all_outs()); end
    endtask

    task automatic test_single_read;
        tick; m_req = 2'b01; m_wr = 2'b00; m_addr[0] = 21'h000C0; smp;
        nchk++;
        if (m_gnt !== 2'b01) begin nfail++; $display("FAIL sr_gnt: got %b want 01", m_gnt); end
        tick; idle_inputs; bus_data = 32'hDEADBEEF; smp;
        nchk++;
        if ({mmio_cs, mmio_wr, mmio_rd, mmio_addr} !== {3'b101, 21'h000C0}) begin
            nfail++; $display("FAIL sr_bus: got cs%b wr%b rd%b addr %h want 101/000c0", mmio_cs, mmio_wr, mmio_rd, mmio_addr);
        end
        tick; bus_data = 32'h0; smp;
        nchk++;
        if ({m_rd_valid, m_rd_data} !== {2'b01, 32'hDEADBEEF}) begin
            nfail++; $display("FAIL sr_ret: got %b/%h want 01/deadbeef", m_rd_valid, m_rd_data);
        end
        tick; smp;
        nchk++;
        if ({m_rd_valid, m_rd_data, mmio_cs, mmio_addr} !== {2'b00, 32'hDEADBEEF, 1'b0, 21'h0}) begin
            nfail++; $display("FAIL sr_after: got v%b d%h cs%b a%h want 00/deadbeef/0/0", m_rd_valid, m_rd_data, mmio_cs, mmio_addr);
        end
    endtask

    task automatic test_contention;
        logic [NM-1:0] want;
        do_reset;
        for (int i = 0; i < 6; i++) begin
            tick; m_req = 2'b11; m_wr = 2'b11; smp;
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            nchk++;
            if (m_gnt !== want) begin nfail++; $display("FAIL contention[%0d]: got %b want %b", i, m_gnt, want); end
        end
        tick; idle_inputs;
    endtask

    task automatic test_lock;
        logic [NM-1:0] want [6];
        want[0] = 2'b10; want[1] = 2'b10; want[2] = 2'b10;
        want[3] = 2'b10; want[4] = 2'b01; want[5] = 2'b10;
        do_reset;
        tick; m_req = 2'b01; m_wr = 2'b11; smp;
        nchk++;
        if (m_gnt !== 2'b01) begin nfail++; $display("FAIL lock_pre: got %b want 01", m_gnt); end
        for (int i = 0; i < 6; i++) begin
            tick; m_req = 2'b11; m_lock = 2'b10; m_wr = 2'b11; smp;
            nchk++;
            if (m_gnt !== want[i]) begin nfail++; $display("FAIL lock[%0d]: got %b want %b", i, m_gnt, want[i]); end
        end
        tick; idle_inputs;
    endtask

    task automatic test_pipelined;
        do_reset;
        tick; m_req = 2'b01; m_wr = 2'b00; m_addr[0] = 21'h00100; m_addr[1] = 21'h00200; smp;
        nchk++;
        if (m_gnt !== 2'b01) begin nfail++; $display("FAIL pipe_g0: got %b want 01", m_gnt); end
        tick; m_req = 2'b10; bus_data = 32'h11; smp;
        nchk++;
        if ({m_gnt, mmio_rd, mmio_addr} !== {2'b10, 1'b1, 21'h00100}) begin
            nfail++; $display("FAIL pipe_g1: got g%b rd%b a%h want 10/1/00100", m_gnt, mmio_rd, mmio_addr);
        end
        tick; m_req = 2'b00; bus_data = 32'h22; smp;
        nchk++;
        if ({m_rd_valid, m_rd_data, mmio_rd, mmio_addr} !== {2'b01, 32'h11, 1'b1, 21'h00200}) begin
            nfail++; $display("FAIL pipe_r0: got v%b d%h rd%b a%h want 01/11/1/00200", m_rd_valid, m_rd_data, mmio_rd, mmio_addr);
        end
        tick; bus_data = 32'h0; smp;
        nchk++;
        if ({m_rd_valid, m_rd_data} !== {2'b10, 32'h22}) begin
            nfail++; $display("FAIL pipe_r1: got %b/%h want 10/22", m_rd_valid, m_rd_data);
        end
        tick; idle_inputs;
    endtask

    task automatic test_write;
        tick; m_req = 2'b10; m_wr = 2'b10; m_addr[1] = 21'h00400; m_wr_data[1] = 32'h5A5A; smp;
        nchk++;
        if (m_gnt !== 2'b10) begin nfail++; $display("FAIL wr_gnt: got %b want 10", m_gnt); end
        tick; idle_inputs; smp;
        nchk++;
        if ({mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data} !== {3'b110, 21'h00400, 32'h5A5A}) begin
            nfail++; $display("FAIL wr_bus: got cs%b wr%b rd%b a%h d%h want 110/00400/5a5a", mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data);
        end
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (m_rd_valid !== 2'b00) begin nfail++; $display("FAIL wr_novalid[%0d]: got %b want 00", i, m_rd_valid); end
            tick; smp;
        end
    endtask

    task automatic test_reset_mid_read;
        tick; m_req = 2'b01; m_wr = 2'b00; m_addr[0] = 21'h00077; smp;
        nchk++;
        if (m_gnt !== 2'b01) begin nfail++; $display("FAIL rmr_gnt: got %b want 01", m_gnt); end
        tick; idle_inputs; reset = 1'b1; bus_data = 32'hCAFE0001;
        tick; reset = 1'b0; bus_data = 32'h0; smp;
        nchk++;
        if (all_outs() !== '0) begin nfail++; $display("FAIL rmr_zero: got %h want 0", all_outs()); end
        tick; m_req = 2'b11; m_wr = 2'b11; smp;
        nchk++;
        if ({m_gnt, m_rd_valid} !== {2'b01, 2'b00}) begin
            nfail++; $display("FAIL rmr_next: got g%b v%b want 01/00", m_gnt, m_rd_valid);
        end
        tick; idle_inputs;
    endtask

    typedef struct {
        bit          pend;
        bit          wr;
        bit          lk;
        logic [20:0] addr;
        logic [31:0] data;
    } mcmd_t;

    task automatic test_random;
        mcmd_t         mc [NM];
        int            ptr, owner, run, g, k, idx;
        bit            pv, pwr, p2rd;
        int            pidx, p2idx;
        logic [20:0]   paddr;
        logic [31:0]   pdata, p2val, last_rd;
        logic [NM-1:0] eg, ev;
        logic [56:0]   eb;
        do_reset;
        use_hash = 1'b1;
        for (int m = 0; m < NM; m++) mc[m].pend = 1'b0;
        ptr = 0; owner = -1; run = 0; pv = 1'b0; p2rd = 1'b0; last_rd = '0;
        pidx = 0; p2idx = 0; pwr = 1'b0; paddr = '0; pdata = '0; p2val = '0;
        for (int c = 0; c < 400; c++) begin
            tick;
            for (int m = 0; m < NM; m++) begin
                if (!mc[m].pend && $urandom_range(3, 0) != 0) begin
                    mc[m].pend = 1'b1;
                    mc[m].wr   = 1'($urandom_range(1, 0));
                    mc[m].lk   = ($urandom_range(2, 0) != 0);
                    mc[m].addr = 21'($urandom);
                    mc[m].data = $urandom;
                end
                m_req[m] = mc[m].pend; m_wr[m] = mc[m].wr; m_lock[m] = mc[m].lk;
                m_addr[m] = mc[m].addr; m_wr_data[m] = mc[m].data;
            end
            smp;
            // locked master wins while requesting; otherwise first requester from ptr
            g = -1;
            if (owner >= 0 && mc[owner].pend) g = owner;
            else for (k = 0; k < NM; k++) begin
                idx = (ptr + k) % NM;
                if (g < 0 && mc[idx].pend) g = idx;
            end
            eg = (g >= 0) ? NM'(1 << g) : '0;
            nchk++;
            if (m_gnt !== eg) begin nfail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, m_gnt, eg); end
            eb = pv ? {1'b1, pwr, ~pwr, paddr, pdata} : '0;
            nchk++;
            if ({mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data} !== eb) begin
                nfail++; $display("FAIL rnd_bus c%0d: got %h want %h", c, {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, eb);
            end
            ev = p2rd ? NM'(1 << p2idx) : '0;
            if (p2rd) last_rd = p2val;
            nchk++;
            if ({m_rd_valid, m_rd_data} !== {ev, last_rd}) begin
                nfail++; $display("FAIL rnd_ret c%0d: got %b/%h want %b/%h", c, m_rd_valid, m_rd_data, ev, last_rd);
            end
            p2rd = pv && !pwr; p2idx = pidx; p2val = hashf(paddr);
            pv = (g >= 0);
            if (g >= 0) begin
                pidx = g; pwr = mc[g].wr; paddr = mc[g].addr; pdata = mc[g].data;
                run = (owner == g) ? run + 1 : 1;
                if (mc[g].lk && run < MAX_LOCK) owner = g;
                else begin owner = -1; run = 0; end
                ptr = (g + 1) % NM;
                mc[g].pend = 1'b0;
            end else begin
                owner = -1; run = 0;
            end
        end
        tick; idle_inputs; use_hash = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_contention;
        test_lock;
        test_pipelined;
        test_write;
        test_reset_mid_read;
        test_random;
        tick; tick;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
